// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC-format IR frame transmitter driving the demodulated line level
// Latency: irda falls one cycle after start is accepted; all outputs registered
// Backpressure: start is taken only while idle (or in the done cycle); ignored while busy
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset (abandons any partial frame)
//   start  frame request, sampled at rising edge of clk
//   addr   NEC address byte, latched at acceptance
//   cmd    NEC command byte, latched at acceptance
//   rpt    repeat-frame request (only when IR_TX_REPEAT_EN is defined)
//   busy   high from frame acceptance until the end of the trailing gap
//   done   one-cycle pulse when the gap completes
//   irda   IR line level; 1 = idle/space, 0 = mark
//
// Optional feature: define IR_TX_REPEAT_EN to add the rpt port and the
// NEC repeat frame (16U mark, 4U space, stop mark, gap).
module ir_nec_tx #(
  parameter int UNIT_CYCLES = 28125,
  parameter int GAP_UNITS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
`ifdef IR_TX_REPEAT_EN
  input  logic       rpt,
`endif
  output logic       busy,
  output logic       done,
  output logic       irda
);

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  // Unit counter must hold the longest state: the gap or the 16U leader mark.
  localparam int UW = $clog2((GAP_UNITS > 16) ? GAP_UNITS : 16) + 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0] GAP_LAST = UW'(GAP_UNITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
`ifdef IR_TX_REPEAT_EN
    REP_SPACE,
`endif
    GAP
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cyc_q, cyc_nxt;
  logic [UW-1:0] unit_q, unit_nxt;
  logic [UW-1:0] units_last;
  logic [4:0]    bit_q, bit_nxt;
  logic [31:0]   word_q, word_nxt;
  logic          done_nxt;
  logic          busy_nxt;
  logic          irda_nxt;
`ifdef IR_TX_REPEAT_EN
  logic          rep_q, rep_nxt;
`endif

  // Index of the last unit of the current state. Bit 0 of the shift word is
  // always the bit being sent, so the space length follows it directly.
  always_comb begin
    units_last = '0;
    case (state_q)
      LEAD_MARK:  units_last = UW'(15);
      LEAD_SPACE: units_last = UW'(7);
      BIT_SPACE:  units_last = word_q[0] ? UW'(2) : UW'(0);
`ifdef IR_TX_REPEAT_EN
      REP_SPACE:  units_last = UW'(3);
`endif
      GAP:        units_last = GAP_LAST;
      default:    units_last = '0;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    cyc_nxt   = cyc_q;
    unit_nxt  = unit_q;
    bit_nxt   = bit_q;
    word_nxt  = word_q;
    done_nxt  = 1'b0;
`ifdef IR_TX_REPEAT_EN
    rep_nxt   = rep_q;
`endif
    if (state_q == IDLE) begin
      if (start) begin
        state_nxt = LEAD_MARK;
        cyc_nxt   = '0;
        unit_nxt  = '0;
        bit_nxt   = '0;
        word_nxt  = {~cmd, cmd, ~addr, addr};
`ifdef IR_TX_REPEAT_EN
        rep_nxt   = rpt;
`endif
      end
    end else if (cyc_q != CYC_LAST) begin
      cyc_nxt = cyc_q + 1'b1;
    end else begin
      cyc_nxt = '0;
      if (unit_q != units_last) begin
        unit_nxt = unit_q + 1'b1;
      end else begin
        unit_nxt = '0;
        case (state_q)
`ifdef IR_TX_REPEAT_EN
          LEAD_MARK:  state_nxt = rep_q ? REP_SPACE : LEAD_SPACE;
          REP_SPACE:  state_nxt = STOP_MARK;
`else
          LEAD_MARK:  state_nxt = LEAD_SPACE;
`endif
          LEAD_SPACE: state_nxt = BIT_MARK;
          BIT_MARK:   state_nxt = BIT_SPACE;
          BIT_SPACE: begin
            word_nxt  = word_q >> 1;
            bit_nxt   = bit_q + 5'd1;
            state_nxt = (bit_q == 5'd31) ? STOP_MARK : BIT_MARK;
          end
          STOP_MARK:  state_nxt = GAP;
          GAP: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
          default:    state_nxt = IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge
  // as the state register, keeping irda glitch-free at unit boundaries.
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    irda_nxt = !((state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) ||
                 (state_nxt == STOP_MARK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      irda    <= 1'b1;
`ifdef IR_TX_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      cyc_q   <= cyc_nxt;
      unit_q  <= unit_nxt;
      bit_q   <= bit_nxt;
      word_q  <= word_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      irda    <= irda_nxt;
`ifdef IR_TX_REPEAT_EN
      rep_q   <= rep_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// tb_ir_nec_tx: self-checking bench for ir_nec_tx (UNIT_CYCLES=4, GAP_UNITS=64)
// The model expands each accepted frame into a per-cycle list of expected
// {irda, busy, done} values; captured waveforms are also decoded by pulse width.
module tb_ir_nec_tx;
  localparam int UC = 4;
  localparam int GU = 64;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] addr;
  logic [7:0] cmd;
`ifdef IR_TX_REPEAT_EN
  logic       rpt;
`endif
  logic       busy;
  logic       done;
  logic       irda;

  int n_chk = 0;
  int n_fail = 0;

  ir_nec_tx #(.UNIT_CYCLES(UC), .GAP_UNITS(GU)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .addr (addr),
    .cmd  (cmd),
`ifdef IR_TX_REPEAT_EN
    .rpt  (rpt),
`endif
    .busy (busy),
    .done (done),
    .irda (irda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] exp_q[$];      // {irda, busy, done} for each upcoming cycle
  logic [2:0] exp_cur = 3'b100;
  bit         model_on = 1'b0;

  function automatic void push_seg(input logic lvl, input int units);
    for (int i = 0; i < units * UC; i++) exp_q.push_back({lvl, 1'b1, 1'b0});
  endfunction

  function automatic void plan_data(input logic [7:0] a, input logic [7:0] c);
    logic [31:0] w;
    w = {~c, c, ~a, a};
    push_seg(1'b0, 16);
    push_seg(1'b1, 8);
    for (int b = 0; b < 32; b++) begin
      push_seg(1'b0, 1);
      push_seg(1'b1, w[b] ? 3 : 1);
    end
    push_seg(1'b0, 1);
    push_seg(1'b1, GU);
    exp_q.push_back(3'b101);
  endfunction

`ifdef IR_TX_REPEAT_EN
  function automatic void plan_rep();
    push_seg(1'b0, 16);
    push_seg(1'b1, 4);
    push_seg(1'b0, 1);
    push_seg(1'b1, GU);
    exp_q.push_back(3'b101);
  endfunction
`endif

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        exp_cur = 3'b100;
      end else begin
        if (!exp_cur[1] && start) begin
`ifdef IR_TX_REPEAT_EN
          if (rpt) plan_rep();
          else plan_data(addr, cmd);
`else
          plan_data(addr, cmd);
`endif
        end
        exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on && !rst) begin
        n_chk++;
        if ({irda, busy, done} !== exp_cur) begin
          n_fail++;
          $display("FAIL model t=%0t {irda,busy,done}: got %b expected %b",
                   $time, {irda, busy, done}, exp_cur);
        end
      end
    end
  end

  // ---------------- waveform capture ----------------
  logic lv[$];
  int   runs[$];
  int   cap_busy;
  int   cap_done;

  // Pulse start for one cycle; returns at the negedge of the first busy cycle.
  task automatic send(input logic [7:0] a, input logic [7:0] c);
    addr  = a;
    cmd   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic capture();
    int n;
    int len;
    n = 0;
    lv.delete();
    runs.delete();
    cap_busy = 0;
    while (!done && n < 3000) begin
      if (busy) begin
        lv.push_back(irda);
        cap_busy++;
      end
      @(negedge clk);
      n++;
    end
    cap_done = int'(done);
    if (lv.size() > 0) begin
      len = 1;
      for (int i = 1; i < lv.size(); i++) begin
        if (lv[i] == lv[i-1]) len++;
        else begin
          runs.push_back(len);
          len = 1;
        end
      end
      runs.push_back(len);
      check("first level is mark", lv[0], 0);
    end
  endtask

  task automatic check_data(input logic [31:0] exp_word);
    logic [31:0] w;
    int bad;
    w = '0;
    bad = 0;
    capture();
    check("done pulse", cap_done, 1);
    check("busy cycles", cap_busy, 740);
    check("run count", runs.size(), 68);
    if (runs.size() == 68) begin
      check("leader mark", runs[0], 64);
      check("leader space", runs[1], 32);
      for (int b = 0; b < 32; b++) begin
        if (runs[2 + 2*b] != 4) bad++;
        if (runs[3 + 2*b] == 12) w[b] = 1'b1;
        else if (runs[3 + 2*b] != 4) bad++;
      end
      check("bit widths", bad, 0);
      check("decoded word", w, exp_word);
      check("stop mark", runs[66], 4);
      check("gap", runs[67], GU * UC);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst   = 1'b0;
    start = 1'b0;
    addr  = '0;
    cmd   = '0;
`ifdef IR_TX_REPEAT_EN
    rpt   = 1'b0;
`endif
    // 1. asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    check("reset irda", irda, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;
    @(negedge clk);
    check("idle irda", irda, 1);
    check("idle busy", busy, 0);

    // 2. basic data frame
    send(8'h00, 8'h45);
    check_data(32'hBA45FF00);

    // 3. start held high: one frame per 741-cycle period
    addr  = 8'h12;
    cmd   = 8'h34;
    start = 1'b1;
    n = 0;
    repeat (3 * 741) begin
      @(negedge clk);
      if (done) n++;
    end
    check("held start last cycle is done", done, 1);
    start = 1'b0;
    check("held start done pulses", n, 3);
    @(negedge clk);

    // 4. reset during bit 10 (cycle 193 is inside its mark)
    send(8'h00, 8'h45);
    repeat (193) @(negedge clk);
    check("bit10 mark before reset", irda, 0);
    #2 rst = 1'b1;
    #1;
    check("midframe reset irda", irda, 1);
    check("midframe reset busy", busy, 0);
    check("midframe reset done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'hA5, 8'h5A);
    check_data(32'hA55A5AA5);

    // 5. inputs changed one cycle after acceptance
    send(8'h81, 8'h7E);
    addr = 8'h00;
    cmd  = 8'hFF;
    check_data(32'h817E7E81);

    // random start pulses and data, including starts while busy
    repeat (4000) begin
      @(negedge clk);
      start = ($urandom_range(0, 39) == 0);
      addr  = 8'($urandom);
      cmd   = 8'($urandom);
`ifdef IR_TX_REPEAT_EN
      rpt   = 1'($urandom_range(0, 1));
`endif
    end
    start = 1'b0;
`ifdef IR_TX_REPEAT_EN
    rpt   = 1'b0;
`endif
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("random phase drains", busy, 0);
    @(negedge clk);

`ifdef IR_TX_REPEAT_EN
    // 6. repeat frame
    rpt = 1'b1;
    send(8'h55, 8'hAA);
    rpt = 1'b0;
    capture();
    check("rep done pulse", cap_done, 1);
    check("rep busy cycles", cap_busy, 340);
    check("rep run count", runs.size(), 4);
    if (runs.size() == 4) begin
      check("rep leader mark", runs[0], 64);
      check("rep space", runs[1], 16);
      check("rep stop mark", runs[2], 4);
      check("rep gap", runs[3], GU * UC);
    end
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
